// File: rtl/exe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// exe_hazard_ctrl_if
// Bundle of the pipeline-side signals that the EX hazard/forwarding controller
// observes and drives.
//   master : pipeline side. Drives the stage info and memory status, and
//            receives the forwarding selects and pipeline control.
//   slave  : the controller (exe_hazard_ctrl).
// Signal groups:
//   ID stage  : id_valid, id_src1, id_src2, id_two_src
//   EX stage  : exe_src1, exe_src2, exe_wb_en, exe_mem_r_en, exe_dest,
//               exe_s, alu_status
//   MEM stage : mem_wb_en, mem_mem_r_en, mem_dest, mem_access, sram_ready
//   WB stage  : wb_wb_en, wb_dest
//   mode      : fwd_en
//   results   : sel_src1, sel_src2, stall, bubble, freeze, status, mem_timeout
// -----------------------------------------------------------------------------
interface exe_hazard_ctrl_if;
  logic       fwd_en;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic [3:0] exe_src1;
  logic [3:0] exe_src2;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic [3:0] exe_dest;
  logic       mem_wb_en;
  logic       mem_mem_r_en;
  logic [3:0] mem_dest;
  logic       wb_wb_en;
  logic [3:0] wb_dest;
  logic       mem_access;
  logic       sram_ready;
  logic       exe_s;
  logic [3:0] alu_status;
  logic [1:0] sel_src1;
  logic [1:0] sel_src2;
  logic       stall;
  logic       bubble;
  logic       freeze;
  logic [3:0] status;
  logic       mem_timeout;

  modport master (
    output fwd_en, id_valid, id_src1, id_src2, id_two_src,
           exe_src1, exe_src2, exe_wb_en, exe_mem_r_en, exe_dest,
           mem_wb_en, mem_mem_r_en, mem_dest, wb_wb_en, wb_dest,
           mem_access, sram_ready, exe_s, alu_status,
    input  sel_src1, sel_src2, stall, bubble, freeze, status, mem_timeout
  );

  modport slave (
    input  fwd_en, id_valid, id_src1, id_src2, id_two_src,
           exe_src1, exe_src2, exe_wb_en, exe_mem_r_en, exe_dest,
           mem_wb_en, mem_mem_r_en, mem_dest, wb_wb_en, wb_dest,
           mem_access, sram_ready, exe_s, alu_status,
    output sel_src1, sel_src2, stall, bubble, freeze, status, mem_timeout
  );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// exe_hazard_ctrl
// Hazard detection and operand forwarding for the execute stage, memory-wait
// freeze with a sticky timeout flag, and the {C,V,N,Z} status register.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : exe_hazard_ctrl_if.slave (see the interface for the signal list)
// Forwarding selects, stall, bubble and freeze are purely combinational;
// status and mem_timeout are registered.
// -----------------------------------------------------------------------------
module exe_hazard_ctrl #(
  parameter int         MEM_TIMEOUT = 255,
  parameter logic [3:0] PC_REG      = 4'd15
) (
  input logic              clk,
  input logic              reset,
  exe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HAZ,
    ST_WAIT
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_inc;
  logic       hazard;
  logic       freeze;
  logic       bubble;
  logic [3:0] status_q;
  logic       mem_timeout_q;

  // Forwarding select for one EX source. A load in MEM carries its address,
  // not its data, so it is skipped and WB gets the chance instead.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       en,
    input logic       m_wb_en,
    input logic       m_r_en,
    input logic [3:0] m_dest,
    input logic       w_wb_en,
    input logic [3:0] w_dest
  );
    if (en && m_wb_en && !m_r_en && m_dest == src && src != PC_REG)
      return 2'b01;
    else if (en && w_wb_en && w_dest == src && src != PC_REG)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // True when the ID instruction actually reads register r.
  function automatic logic id_uses(
    input logic [3:0] r,
    input logic       valid,
    input logic [3:0] src1,
    input logic       two_src,
    input logic [3:0] src2
  );
    return valid && ((src1 == r) || (two_src && src2 == r)) && (r != PC_REG);
  endfunction

  always_comb begin
    logic use_exe;
    logic use_mem;
    use_exe = id_uses(bus.exe_dest, bus.id_valid, bus.id_src1,
                      bus.id_two_src, bus.id_src2);
    use_mem = id_uses(bus.mem_dest, bus.id_valid, bus.id_src1,
                      bus.id_two_src, bus.id_src2);
    // With forwarding only a load in EX cannot be bypassed in time; without
    // it every producer still ahead of WB must drain first.
    if (bus.fwd_en)
      hazard = bus.exe_wb_en && bus.exe_mem_r_en && use_exe;
    else
      hazard = (bus.exe_wb_en && use_exe) || (bus.mem_wb_en && use_mem);
  end

  assign freeze = bus.mem_access && !bus.sram_ready;
  // Freeze dominates: the whole pipe holds, so no bubble may be inserted.
  assign bubble = hazard && !freeze;

  assign bus.freeze      = freeze;
  assign bus.stall       = bubble;
  assign bus.bubble      = bubble;
  assign bus.sel_src1    = fwd_sel(bus.exe_src1, bus.fwd_en, bus.mem_wb_en,
                                   bus.mem_mem_r_en, bus.mem_dest,
                                   bus.wb_wb_en, bus.wb_dest);
  assign bus.sel_src2    = fwd_sel(bus.exe_src2, bus.fwd_en, bus.mem_wb_en,
                                   bus.mem_mem_r_en, bus.mem_dest,
                                   bus.wb_wb_en, bus.wb_dest);
  assign bus.status      = status_q;
  assign bus.mem_timeout = mem_timeout_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_next;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:  if (freeze) state_next = ST_WAIT;
               else if (hazard) state_next = ST_HAZ;
      ST_HAZ:  if (freeze) state_next = ST_WAIT;
               else if (!hazard) state_next = ST_RUN;
      ST_WAIT: if (!freeze) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  assign wait_cnt_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

  // Only cycles already in WAIT are counted; the cycle that enters WAIT is not.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt      <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else if (!freeze) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt_inc;
      if (wait_cnt_inc >= TIMEOUT_CNT) mem_timeout_q <= 1'b1;
    end
  end

  // A bubbled or frozen EX slot is not a real instruction, so it must not
  // commit flags.
  always_ff @(posedge clk) begin
    if (!reset)
      status_q <= 4'd0;
    else if (bus.exe_s && !freeze && !bubble)
      status_q <= bus.alu_status;
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exe_hazard_ctrl
// Directed bench for exe_hazard_ctrl (MEM_TIMEOUT = 3). Inputs change 1 ns
// after a rising edge; combinational outputs are checked 1 ns later and
// registered outputs are checked 1 ns after the edge that updates them.
// -----------------------------------------------------------------------------
module tb_exe_hazard_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  exe_hazard_ctrl_if hif ();

  exe_hazard_ctrl #(.MEM_TIMEOUT(3), .PC_REG(4'd15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.fwd_en       = 1'b1;
    hif.id_valid     = 1'b0;
    hif.id_src1      = 4'd0;
    hif.id_src2      = 4'd0;
    hif.id_two_src   = 1'b0;
    hif.exe_src1     = 4'd0;
    hif.exe_src2     = 4'd0;
    hif.exe_wb_en    = 1'b0;
    hif.exe_mem_r_en = 1'b0;
    hif.exe_dest     = 4'd0;
    hif.mem_wb_en    = 1'b0;
    hif.mem_mem_r_en = 1'b0;
    hif.mem_dest     = 4'd0;
    hif.wb_wb_en     = 1'b0;
    hif.wb_dest      = 4'd0;
    hif.mem_access   = 1'b0;
    hif.sram_ready   = 1'b0;
    hif.exe_s        = 1'b0;
    hif.alu_status   = 4'd0;
  endtask

  // Load r5 in EX, ID instruction reading r5 on its second source.
  task automatic load_use_setup();
    hif.exe_wb_en    = 1'b1;
    hif.exe_mem_r_en = 1'b1;
    hif.exe_dest     = 4'd5;
    hif.id_valid     = 1'b1;
    hif.id_src1      = 4'd0;
    hif.id_src2      = 4'd5;
    hif.id_two_src   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();

    // ---- reset dominates a status write ----
    reset = 1'b0;
    hif.exe_s      = 1'b1;
    hif.alu_status = 4'hF;
    tick();
    check("rst_status", 8'(hif.status), 8'h0);
    check("rst_timeout", 8'(hif.mem_timeout), 8'h0);
    check("rst_stall", 8'(hif.stall), 8'h0);
    check("rst_freeze", 8'(hif.freeze), 8'h0);
    reset = 1'b1;
    tick();
    check("status_load", 8'(hif.status), 8'hF);
    hif.exe_s      = 1'b0;
    hif.alu_status = 4'h3;
    tick();
    check("status_hold", 8'(hif.status), 8'hF);

    // ---- forwarding priority ----
    hif.exe_src1  = 4'd3;
    hif.mem_dest  = 4'd3;
    hif.wb_dest   = 4'd3;
    hif.mem_wb_en = 1'b1;
    hif.wb_wb_en  = 1'b1;
    #1;
    check("fwd_mem", 8'(hif.sel_src1), 8'h1);
    check("fwd_src2_none", 8'(hif.sel_src2), 8'h0);
    hif.mem_mem_r_en = 1'b1;
    #1;
    check("fwd_load_skip", 8'(hif.sel_src1), 8'h2);
    hif.exe_src2 = 4'd3;
    #1;
    check("fwd_wb_src2", 8'(hif.sel_src2), 8'h2);
    hif.exe_src1 = 4'd15;
    hif.mem_dest = 4'd15;
    hif.wb_dest  = 4'd15;
    hif.mem_mem_r_en = 1'b0;
    #1;
    check("fwd_pc_reg", 8'(hif.sel_src1), 8'h0);
    hif.exe_src1 = 4'd3;
    hif.mem_dest = 4'd3;
    hif.fwd_en   = 1'b0;
    #1;
    check("fwd_disabled", 8'(hif.sel_src1), 8'h0);
    clear_inputs();
    tick();

    // ---- load-use: one bubble, then WB forwarding ----
    load_use_setup();
    hif.exe_s      = 1'b1;
    hif.alu_status = 4'h6;
    #1;
    check("lu_stall", 8'(hif.stall), 8'h1);
    check("lu_bubble", 8'(hif.bubble), 8'h1);
    tick();
    check("lu_status_blocked", 8'(hif.status), 8'hF);
    // bubble now in EX, load in MEM, consumer still held in ID
    hif.exe_s        = 1'b0;
    hif.exe_wb_en    = 1'b0;
    hif.exe_mem_r_en = 1'b0;
    hif.exe_dest     = 4'd0;
    hif.mem_wb_en    = 1'b1;
    hif.mem_mem_r_en = 1'b1;
    hif.mem_dest     = 4'd5;
    #1;
    check("lu_cycle1_stall", 8'(hif.stall), 8'h0);
    tick();
    // consumer in EX, load in WB
    hif.id_valid     = 1'b0;
    hif.exe_src2     = 4'd5;
    hif.mem_wb_en    = 1'b0;
    hif.mem_mem_r_en = 1'b0;
    hif.mem_dest     = 4'd0;
    hif.wb_wb_en     = 1'b1;
    hif.wb_dest      = 4'd5;
    #1;
    check("lu_cycle2_sel", 8'(hif.sel_src2), 8'h2);
    check("lu_cycle2_stall", 8'(hif.stall), 8'h0);
    tick();
    clear_inputs();
    load_use_setup();
    hif.id_two_src = 1'b0;
    hif.id_src1    = 4'd1;
    #1;
    check("lu_one_src", 8'(hif.stall), 8'h0);
    hif.id_src1 = 4'd5;
    #1;
    check("lu_src1", 8'(hif.stall), 8'h1);
    clear_inputs();
    tick();

    // ---- no-forward mode: ALU producer stalls two cycles ----
    hif.fwd_en    = 1'b0;
    hif.exe_wb_en = 1'b1;
    hif.exe_dest  = 4'd2;
    hif.id_valid  = 1'b1;
    hif.id_src1   = 4'd2;
    #1;
    check("nf_exe_stall", 8'(hif.stall), 8'h1);
    tick();
    hif.exe_wb_en = 1'b0;
    hif.exe_dest  = 4'd0;
    hif.mem_wb_en = 1'b1;
    hif.mem_dest  = 4'd2;
    #1;
    check("nf_mem_stall", 8'(hif.stall), 8'h1);
    tick();
    hif.id_valid  = 1'b0;
    hif.exe_src1  = 4'd2;
    hif.mem_wb_en = 1'b0;
    hif.mem_dest  = 4'd0;
    hif.wb_wb_en  = 1'b1;
    hif.wb_dest   = 4'd2;
    #1;
    check("nf_wb_stall", 8'(hif.stall), 8'h0);
    check("nf_wb_sel", 8'(hif.sel_src1), 8'h0);
    clear_inputs();
    tick();

    // ---- memory wait with a concurrent load-use hazard ----
    load_use_setup();
    hif.mem_access = 1'b1;
    hif.exe_s      = 1'b1;
    hif.alu_status = 4'hA;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mw_freeze", 8'(hif.freeze), 8'h1);
      check("mw_stall", 8'(hif.stall), 8'h0);
      check("mw_bubble", 8'(hif.bubble), 8'h0);
      tick();
      check("mw_status_hold", 8'(hif.status), 8'hF);
    end
    // entry cycle uncounted, then three counted WAIT cycles reach the limit
    check("mw_timeout_set", 8'(hif.mem_timeout), 8'h1);
    hif.sram_ready = 1'b1;
    #1;
    check("mw_pulse_freeze", 8'(hif.freeze), 8'h0);
    check("mw_pulse_stall", 8'(hif.stall), 8'h1);
    tick();
    check("mw_pulse_status", 8'(hif.status), 8'hF);
    check("mw_timeout_sticky", 8'(hif.mem_timeout), 8'h1);
    clear_inputs();
    hif.exe_s      = 1'b1;
    hif.alu_status = 4'hA;
    tick();
    check("mw_status_after", 8'(hif.status), 8'hA);

    // ---- reset mid-WAIT ----
    hif.mem_access = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_wait_status", 8'(hif.status), 8'h0);
    check("rst_wait_timeout", 8'(hif.mem_timeout), 8'h0);
    clear_inputs();
    reset = 1'b1;
    tick();

    // ---- timeout: counter clears on a non-freeze cycle ----
    hif.mem_access = 1'b1;
    tick();
    tick();
    hif.mem_access = 1'b0;
    tick();
    hif.mem_access = 1'b1;
    tick();
    check("to_entry", 8'(hif.mem_timeout), 8'h0);
    tick();
    check("to_cnt1", 8'(hif.mem_timeout), 8'h0);
    tick();
    check("to_cnt2", 8'(hif.mem_timeout), 8'h0);
    tick();
    check("to_cnt3", 8'(hif.mem_timeout), 8'h1);
    tick();
    check("to_cnt4", 8'(hif.mem_timeout), 8'h1);
    hif.sram_ready = 1'b1;
    tick();
    check("to_after_ready", 8'(hif.mem_timeout), 8'h1);
    clear_inputs();
    tick();
    check("to_idle", 8'(hif.mem_timeout), 8'h1);
    reset = 1'b0;
    tick();
    check("to_reset", 8'(hif.mem_timeout), 8'h0);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/exe_hazard_ctrl.md
# exe_hazard_ctrl

Pipeline hazard and forwarding controller for the execute datapath. It computes the two forwarding selects (`sel_src1`/`sel_src2`) for the EX-stage operand muxes and detects read-after-write hazards against the EX-stage instruction. It freezes the whole pipeline while the memory controller is busy. It also owns the architectural status register {C,V,N,Z}, updated from the EX-stage ALU flags.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: consecutive freeze cycles after which `mem_timeout` is raised.
- `PC_REG`, 4'd15: register index that is never forwarded and never causes a hazard.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `fwd_en` in 1: 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_src1`, `id_src2` in 4: ID-stage source register indices.
- `id_two_src` in 1: `id_src2` is actually read.
- `exe_src1`, `exe_src2` in 4: source register indices of the instruction in EX.
- `exe_wb_en`, `exe_mem_r_en` in 1; `exe_dest` in 4: EX-stage writeback info.
- `mem_wb_en`, `mem_mem_r_en` in 1; `mem_dest` in 4: MEM-stage writeback info.
- `wb_wb_en` in 1; `wb_dest` in 4: WB-stage writeback info.
- `mem_access` in 1: MEM stage holds a load/store (level).
- `sram_ready` in 1: memory controller completion pulse.
- `exe_s` in 1: EX instruction updates status.
- `alu_status` in 4: {C,V,N,Z} from the ALU.
- `sel_src1`, `sel_src2` out 2: 00 register file, 01 MEM ALU result, 10 WB value (11 never driven).
- `stall` out 1: hold PC and the IF/ID register.
- `bubble` out 1: load a NOP into ID/EX.
- `freeze` out 1: hold all pipeline registers.
- `status` out 4: registered {C,V,N,Z}.
- `mem_timeout` out 1: sticky error flag.

## Operation
- **freeze** = `mem_access & ~sram_ready`.
  - Freeze dominates: while `freeze` = 1, `stall` = `bubble` = 0, and no state other than the FSM and the timeout counter changes.
- **Forwarding.** Computed combinationally per source s ∈ {`exe_src1`, `exe_src2`}:
  - if `fwd_en` & `mem_wb_en` & ~`mem_mem_r_en` & `mem_dest` == s & s != `PC_REG` → 01;
  - else if `fwd_en` & `wb_wb_en` & `wb_dest` == s & s != `PC_REG` → 10;
  - else → 00.
  - MEM takes priority over WB. A load in MEM is never forwarded, because its ALU result is the address, not the data.
- **Hazard.** Let `use(r)` = `id_valid` & ((`id_src1` == r) | (`id_two_src` & `id_src2` == r)) & r != `PC_REG`.
  - `fwd_en` = 1: hazard = `exe_wb_en` & `exe_mem_r_en` & `use(exe_dest)` (load-use only).
  - `fwd_en` = 0: hazard = (`exe_wb_en` & `use(exe_dest)`) | (`mem_wb_en` & `use(mem_dest)`).
  - `stall` = `bubble` = hazard & ~`freeze`.
- **FSM** states RUN, HAZ, WAIT; resets to RUN.
  - RUN → WAIT if `freeze`; else → HAZ if hazard; else stay in RUN.
  - HAZ → WAIT if `freeze`; else → RUN if ~hazard; else stay in HAZ.
  - WAIT → RUN if ~`freeze`; else stay in WAIT.
- **Timeout counter** (8-bit): increments each cycle in WAIT with `freeze` = 1, saturating at 255, and clears on any non-freeze cycle.
  - When the count reaches `MEM_TIMEOUT`, `mem_timeout` is set.
  - `mem_timeout` is cleared only by reset.
- **Status register:** loads `alu_status` on the clock edge when `exe_s` & ~`freeze` & ~`bubble`; otherwise it holds.

## Timing
- Reset values, applied at the first rising edge with `reset` = 0: `status` = 0, `mem_timeout` = 0, FSM = RUN, counter = 0.
  - `sel_src*`, `stall`, `bubble` and `freeze` are combinational and depend only on inputs.
- Forwarding, `stall`, `bubble` and `freeze` have zero latency (valid in the same cycle as their inputs).
- `status` reflects the EX instruction one cycle after it is in EX.
- Load-use with `fwd_en` = 1 costs exactly one bubble:
  - cycle 0: load in EX → `stall` = 1;
  - cycle 1: bubble in EX, no hazard;
  - cycle 2: consumer in EX gets `sel` = 10.
- With `fwd_en` = 0, a dependency on an ALU op in EX stalls 2 cycles. The hazard persists while the producer is in MEM, and clears once it reaches WB (the register file writes on the first half).
- Memory stall and hazard in the same cycle: `freeze` = 1, `stall` = 0. The hazard re-evaluates after `freeze` drops.
- An `sram_ready` pulse with `mem_access` = 1 gives `freeze` = 0 in that same cycle, and the pipeline advances.
- Reset asserted mid-WAIT or mid-HAZ: all registers return to their reset values at the next edge, regardless of the other inputs.

## Test plan
- **Reset:** drive `reset` = 0 with `exe_s` = 1, `alu_status` = 4'hF → `status` = 0, `mem_timeout` = 0. Release reset, then one cycle with `exe_s` = 1 → `status` = 4'hF.
- **Forward priority:** `exe_src1` = 3, `mem_dest` = 3, `wb_dest` = 3, both wb_en = 1, `fwd_en` = 1 → `sel_src1` = 01. Set `mem_mem_r_en` = 1 → 10. Set `exe_src1` = 15 → 00.
- **Load-use:** `exe_mem_r_en` = `exe_wb_en` = 1, `exe_dest` = 5, `id_src2` = 5, `id_two_src` = 1 → `stall` = `bubble` = 1 for exactly 1 cycle. Same case with `id_two_src` = 0 → no stall.
- **No-forward mode:** `fwd_en` = 0, ALU op writing r2 in EX, consumer reading r2 in ID → stall for 2 cycles, then `sel_src1` = 00.
- **Memory wait:** `mem_access` = 1, `sram_ready` low for 4 cycles then pulsed → `freeze` = 1 for 4 cycles, 0 on the pulse cycle. A concurrent hazard gives `stall` = 0 throughout; `status` does not change during freeze.
- **Timeout:** `MEM_TIMEOUT` = 3, hold `freeze` for 5 cycles → `mem_timeout` rises after the 3rd counted WAIT cycle and stays 1 after `sram_ready`, until `reset` = 0.
